branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage pipelined MIPS core. It combines a direct-mapped branch target buffer with per-entry saturating counters.
- Fetch looks up pcF and steers the next PC.
- Decode resolves branches and jumps, then updates the tables and flags mispredictions so the pipeline can redirect and flush.
- The current core resolves every branch statically in Decode; this block replaces that with configurable-depth, configurable-counter prediction and adds performance counters.

---
 rtl/branch_predictor_pkg.sv | 58 +++++
 rtl/branch_predictor_sat_counter.sv | 52 +++++
 rtl/branch_predictor.sv | 150 +++++++++++++++
 tb/tb_branch_predictor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg (package)
// Description : Shared types and helpers for the branch predictor.
//               It holds the BTB entry layout for the default configuration,
//               the saturating counter step functions, and the weakly
//               taken / weakly not-taken counter constants.
//               Counter values are carried in a 4-bit container because
//               CTR_BITS never exceeds 4. Callers narrow the result to their
//               own width.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Default geometry; the top-level parameters override these widths.
    localparam int BP_WIDTH     = 32;
    localparam int BP_ENTRIES   = 64;
    localparam int BP_IDXW      = $clog2(BP_ENTRIES);
    localparam int BP_TAGW      = BP_WIDTH - BP_IDXW - 2;
    localparam int BP_CTR_BITS  = 2;
    localparam int CTR_MAX_BITS = 4;

    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAGW-1:0]     tag;
        logic [BP_WIDTH-1:0]    target;
        logic [BP_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    // Returns 2^(bits-1), the weakly-taken value. For 1 bit this is 1.
    function automatic ctr_t ctr_weak_t(input int bits);
        return ctr_t'(1) << (bits - 1);
    endfunction

    // Returns 2^(bits-1)-1, the weakly-not-taken value. For 1 bit this is 0.
    function automatic ctr_t ctr_weak_nt(input int bits);
        return ctr_weak_t(bits) - ctr_t'(1);
    endfunction

    localparam ctr_t CTR_WEAK_T  = ctr_weak_t(BP_CTR_BITS);
    localparam ctr_t CTR_WEAK_NT = ctr_weak_nt(BP_CTR_BITS);

    // Increments v and saturates at 2^bits-1.
    function automatic ctr_t sat_inc(input ctr_t v, input int bits);
        ctr_t max_v;
        max_v = ctr_t'((1 << bits) - 1);
        return (v >= max_v) ? max_v : v + ctr_t'(1);
    endfunction

    // Decrements v and saturates at zero.
    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : CTR_BITS-wide saturating up/down counter with a load input.
//               Load takes priority over inc, and inc takes priority over
//               dec. Reset sets the counter to weakly not-taken.
// Ports       : clk, reset (async, active low), inc, dec, load,
//               load_val[CTR_BITS], count[CTR_BITS]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    input  logic [CTR_BITS-1:0] load_val,
    output logic [CTR_BITS-1:0] count
);

    localparam logic [CTR_BITS-1:0] RESET_VAL = CTR_BITS'(ctr_weak_nt(CTR_BITS));

    logic [CTR_BITS-1:0] count_q;
    logic [CTR_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = CTR_BITS'(sat_inc(ctr_t'(count_q), CTR_BITS));
        end else if (dec) begin
            count_d = CTR_BITS'(sat_dec(ctr_t'(count_q)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with one saturating direction counter per
//               entry.
//               - Lookup in Fetch is combinational from registered state.
//               - Update in Decode takes effect on the clock edge.
//               - A lookup sees the contents from before any update in the
//                 same cycle; there is no bypass.
//               - Two saturating statistics counters track resolved
//                 branches and mispredictions.
// Ports       : clk, reset (async, active low)
//               Fetch  : pcF -> predtakenF, predtargetF
//               Decode : updateD, pcD, takenD, targetD, predtakenD,
//                        predtargetD, flushallD -> mispredictD
//               Stats  : branchcount, mispredcount
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     pcF,
    output logic                 predtakenF,
    output logic [WIDTH-1:0]     predtargetF,
    input  logic                 updateD,
    input  logic [WIDTH-1:0]     pcD,
    input  logic                 takenD,
    input  logic [WIDTH-1:0]     targetD,
    input  logic                 predtakenD,
    input  logic [WIDTH-1:0]     predtargetD,
    input  logic                 flushallD,
    output logic                 mispredictD,
    output logic [STAT_BITS-1:0] branchcount,
    output logic [STAT_BITS-1:0] mispredcount
);

    localparam int                   IDXW      = $clog2(ENTRIES);
    localparam int                   TAGW      = WIDTH - IDXW - 2;
    localparam logic [CTR_BITS-1:0]  CTR_ALLOC = CTR_BITS'(ctr_weak_t(CTR_BITS));
    localparam logic [STAT_BITS-1:0] STAT_MAX  = '1;

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAGW-1:0]      tag_q    [ENTRIES];
    logic [TAGW-1:0]      tag_d    [ENTRIES];
    logic [WIDTH-1:0]     target_q [ENTRIES];
    logic [WIDTH-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0]  ctr      [ENTRIES];
    logic [STAT_BITS-1:0] branchcount_q, branchcount_d;
    logic [STAT_BITS-1:0] mispredcount_q, mispredcount_d;

    logic [IDXW-1:0] idx_fetch, idx_dec;
    logic [TAGW-1:0] tag_fetch, tag_dec;
    logic            hit_fetch, hit_dec;
    logic            tbl_wr, ctr_upd, ctr_alloc;
    logic            unused_pc_lsbs;

    assign idx_fetch = pcF[IDXW+1:2];
    assign tag_fetch = pcF[WIDTH-1:IDXW+2];
    assign idx_dec   = pcD[IDXW+1:2];
    assign tag_dec   = pcD[WIDTH-1:IDXW+2];

    // The byte offset within a word plays no part in indexing.
    assign unused_pc_lsbs = ^{pcF[1:0], pcD[1:0]};

    // Fetch lookup
    assign hit_fetch   = valid_q[idx_fetch] && (tag_q[idx_fetch] == tag_fetch);
    assign predtakenF  = hit_fetch && ctr[idx_fetch][CTR_BITS-1];
    assign predtargetF = predtakenF ? target_q[idx_fetch] : pcF + WIDTH'(4);

    // Decode resolution
    assign hit_dec     = valid_q[idx_dec] && (tag_q[idx_dec] == tag_dec);
    assign mispredictD = updateD &&
                         ((predtakenD != takenD) || (takenD && (predtargetD != targetD)));

    // A flush suppresses every table write in its cycle, including allocation.
    assign tbl_wr    = updateD && !flushallD;
    assign ctr_upd   = tbl_wr && hit_dec;
    assign ctr_alloc = tbl_wr && !hit_dec && takenD;

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        logic sel;
        assign sel = (idx_dec == IDXW'(e));

        sat_counter #(
            .CTR_BITS (CTR_BITS)
        ) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .inc      (sel && ctr_upd && takenD),
            .dec      (sel && ctr_upd && !takenD),
            .load     (sel && ctr_alloc),
            .load_val (CTR_ALLOC),
            .count    (ctr[e])
        );
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (flushallD) begin
            valid_d = '0;
        end else if (updateD && takenD) begin
            // A taken hit and a taken allocation both write the target.
            // Only allocation changes valid and tag.
            target_d[idx_dec] = targetD;
            if (!hit_dec) begin
                valid_d[idx_dec] = 1'b1;
                tag_d[idx_dec]   = tag_dec;
            end
        end

        branchcount_d  = branchcount_q;
        mispredcount_d = mispredcount_q;
        if (updateD && (branchcount_q != STAT_MAX)) begin
            branchcount_d = branchcount_q + STAT_BITS'(1);
        end
        if (mispredictD && (mispredcount_q != STAT_MAX)) begin
            mispredcount_d = mispredcount_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q        <= '0;
            tag_q          <= '{default: '0};
            target_q       <= '{default: '0};
            branchcount_q  <= '0;
            mispredcount_q <= '0;
        end else begin
            valid_q        <= valid_d;
            tag_q          <= tag_d;
            target_q       <= target_d;
            branchcount_q  <= branchcount_d;
            mispredcount_q <= mispredcount_d;
        end
    end

    assign branchcount  = branchcount_q;
    assign mispredcount = mispredcount_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. It drives a
//               default instance and a STAT_BITS=4 instance from the same
//               stimulus. A table model kept as plain arrays, with
//               unbounded statistics clamped at compare time, supplies
//               every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int N_ENT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcF = '0, pcD = '0, targetD = '0, predtargetD = '0;
    logic        updateD = 1'b0, takenD = 1'b0, predtakenD = 1'b0, flushallD = 1'b0;

    logic        predtakenF, mispredictD, pt4, mis4;
    logic [31:0] predtargetF, tgt4, branchcount, mispredcount;
    logic [3:0]  bc4, mc4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid [N_ENT];
    logic [31:0] m_tag   [N_ENT];
    logic [31:0] m_tgt   [N_ENT];
    int          m_ctr   [N_ENT];
    longint      m_bc, m_mc;

    branch_predictor u_dut (
        .clk(clk), .reset(reset), .pcF(pcF), .predtakenF(predtakenF),
        .predtargetF(predtargetF), .updateD(updateD), .pcD(pcD), .takenD(takenD),
        .targetD(targetD), .predtakenD(predtakenD), .predtargetD(predtargetD),
        .flushallD(flushallD), .mispredictD(mispredictD),
        .branchcount(branchcount), .mispredcount(mispredcount)
    );

    branch_predictor #(.STAT_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .pcF(pcF), .predtakenF(pt4),
        .predtargetF(tgt4), .updateD(updateD), .pcD(pcD), .takenD(takenD),
        .targetD(targetD), .predtakenD(predtakenD), .predtargetD(predtargetD),
        .flushallD(flushallD), .mispredictD(mis4),
        .branchcount(bc4), .mispredcount(mc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N_ENT);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * N_ENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    // The 2-bit counter predicts taken from value 2 upward.
    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic longint clamp(input longint v, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ENT; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_edge(input bit mis);
        int i;
        i = idx_of(pcD);
        if (flushallD) begin
            for (int k = 0; k < N_ENT; k++) m_valid[k] = 1'b0;
        end else if (updateD) begin
            if (m_hit(pcD)) begin
                if (takenD) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = targetD;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (takenD) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(pcD);
                m_tgt[i]   = targetD;
                m_ctr[i]   = 2;
            end
        end
        if (updateD) m_bc++;
        if (mis) m_mc++;
    endtask

    task automatic set_in(input logic [31:0] pf, input bit upd, input logic [31:0] pd,
                          input bit tk, input logic [31:0] tgt, input bit pt,
                          input logic [31:0] ptgt, input bit fl);
        pcF = pf; updateD = upd; pcD = pd; takenD = tk;
        targetD = tgt; predtakenD = pt; predtargetD = ptgt; flushallD = fl;
    endtask

    // Decode update whose carried prediction is what Fetch would have predicted.
    task automatic upd_real(input logic [31:0] pf, input logic [31:0] pd,
                            input bit tk, input logic [31:0] tgt);
        set_in(pf, 1'b1, pd, tk, tgt, m_pt(pd), m_ptgt(pd), 1'b0);
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic tick();
        bit mis;
        @(negedge clk);
        mis = updateD && ((predtakenD != takenD) || (takenD && (predtargetD != targetD)));
        check("predtakenF",    predtakenF,   m_pt(pcF));
        check("predtargetF",   predtargetF,  m_ptgt(pcF));
        check("mispredictD",   mispredictD,  mis);
        check("branchcount",   branchcount,  clamp(m_bc, 32));
        check("mispredcount",  mispredcount, clamp(m_mc, 32));
        check("predtakenF4",   pt4,          m_pt(pcF));
        check("branchcount4",  bc4,          clamp(m_bc, 4));
        check("mispredcount4", mc4,          clamp(m_mc, 4));
        @(posedge clk);
        if (reset) model_edge(mis);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h0040_0000 | ($urandom_range(0, 1) << 8) |
               ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        logic [31:0] rp, rt;
        bit          rk;

        // Reset state
        model_reset();
        #2 reset = 1'b0;
        set_in(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
        #6;
        check("rst_predtakenF",  predtakenF,  1'b0);
        check("rst_predtargetF", predtargetF, 32'h0040_0014);
        check("rst_branchcount", branchcount, 0);
        check("rst_mispredcnt",  mispredcount, 0);
        tick();
        reset = 1'b1;

        // First taken branch misses and is mispredicted
        set_in(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0040_0014, 0);
        #1 check("tp_first_mispredict", mispredictD, 1'b1);
        tick();
        set_in(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("tp_alloc_taken",  predtakenF,   1'b1);
        check("tp_alloc_target", predtargetF,  32'h0040_0100);
        check("tp_mispredcount", mispredcount, 1);
        tick();

        // Four not-taken updates walk the counter down to zero
        for (int k = 0; k < 4; k++) begin
            upd_real(32'h0040_0010, 32'h0040_0010, 1'b0, 32'h0);
            tick();
            if (k == 0) begin
                #1 check("tp_nt_after_first", predtakenF, 1'b0);
            end
        end
        // Two taken updates bring it back to taken
        for (int k = 0; k < 2; k++) begin
            upd_real(32'h0040_0010, 32'h0040_0010, 1'b1, 32'h0040_0100);
            tick();
        end
        set_in(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
        #1 check("tp_retaken", predtakenF, 1'b1);
        tick();

        // Aliasing: same index, different tag replaces the entry
        upd_real(32'h0040_0010, 32'h0040_0110, 1'b1, 32'h0040_0200);
        tick();
        set_in(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
        #1 check("tp_alias_miss", predtakenF, 1'b0);
        tick();
        set_in(32'h0040_0110, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Flush with a simultaneous taken miss: nothing gets allocated
        set_in(32'h0040_0110, 1, 32'h0040_0040, 1, 32'h0040_0300, 0, 32'h0040_0044, 1);
        tick();
        set_in(32'h0040_0040, 0, 0, 0, 0, 0, 0, 0);
        #1 check("tp_flush_no_alloc", predtakenF, 1'b0);
        tick();
        set_in(32'h0040_0110, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rp = rand_pc();
            rk = $urandom_range(0, 1);
            rt = 32'h0040_0000 | ($urandom_range(0, 15) << 4);
            if ($urandom_range(0, 3) != 0)
                upd_real(rand_pc(), rp, rk, rt);
            else
                set_in(rand_pc(), 1'b1, rp, rk, rt, 1'($urandom_range(0, 1)),
                       32'h0040_0000 | ($urandom_range(0, 15) << 4), 1'b0);
            if ($urandom_range(0, 9) < 3) updateD = 1'b0;
            if ($urandom_range(0, 39) == 0) flushallD = 1'b1;
            tick();
        end

        // Asynchronous reset mid-run with a taken entry present
        upd_real(32'h0040_0010, 32'h0040_0010, 1'b1, 32'h0040_0100);
        tick();
        upd_real(32'h0040_0010, 32'h0040_0010, 1'b1, 32'h0040_0100);
        tick();
        set_in(32'h0040_0010, 1, 32'h0040_0020, 1, 32'h0040_0400, 0, 32'h0040_0024, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("tp_async_rst_pt", predtakenF, 1'b0);
        check("tp_async_rst_bc", branchcount, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        set_in(32'h0040_0020, 0, 0, 0, 0, 0, 0, 0);
        #1 check("tp_rst_update_discarded", predtakenF, 1'b0);
        tick();

        // Twenty updates: the 4-bit statistics hold at 15
        for (int n = 0; n < 20; n++) begin
            upd_real(rand_pc(), rand_pc(), 1'($urandom_range(0, 1)),
                     32'h0040_0000 | ($urandom_range(0, 15) << 4));
            tick();
        end
        set_in(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("tp_stat4_saturate", bc4, 4'd15);
        check("tp_stat32_count",   branchcount, 20);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
